control_pipeline: RTL and testbench

//  Receiver of the ID-stage control bundles {PC_ctrl, EX_ctrl, MEM_ctrl, WB_ctrl} from the general decoder.

---
 rtl/control_pipeline.sv | 227 ++++++++++++++++++++++
 tb/tb_control_pipeline.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_pipeline.sv
`default_nettype none
// ============================================================================
//  Module   : control_pipeline
//  Purpose  : Carries decoded control bundles through ID/EX, EX/MEM, MEM/WB and
//             generates hazard stall, IF/ID flush and operand forwarding selects.
//  Options  : CTRL_PIPE_FWD_EN - forwarding + load-use stall; undefined gives
//             a stall-until-written interlock with fwd selects tied to 00.
//  Revision : 1.0 - initial release
// ============================================================================
module control_pipeline #(
    parameter int RA_W    = 5,
    parameter int ALUOP_W = 3
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               id_valid_i,
    input  logic [1:0]         pc_ctrl_i,
    input  logic [ALUOP_W+1:0] ex_ctrl_i,
    input  logic [1:0]         mem_ctrl_i,
    input  logic [1:0]         wb_ctrl_i,
    input  logic [RA_W-1:0]    rs_i,
    input  logic [RA_W-1:0]    rt_i,
    input  logic [RA_W-1:0]    rd_i,
    input  logic               flush_i,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic               alu_src_o,
    output logic [1:0]         fwd_a_o,
    output logic [1:0]         fwd_b_o,
    output logic               mem_cs_o,
    output logic               mem_we_o,
    output logic               wb_mux_o,
    output logic               reg_we_o,
    output logic [RA_W-1:0]    wb_dst_o,
    output logic               stall_o,
    output logic               pc_write_o,
    output logic               flush_if_o
);

    localparam logic [RA_W-1:0] c_reg_zero = '0;
    localparam logic [1:0]      c_fwd_rf   = 2'b00;

    // ------------------------------------------------------------------
    // ID stage decode
    // ------------------------------------------------------------------
    logic [ALUOP_W-1:0] w_id_alu_op;
    logic               w_id_alu_src;
    logic               w_id_reg_dst;
    logic [RA_W-1:0]    w_id_dst;
    logic               w_id_bubble;
    logic               w_hazard;
    logic               w_stall;
    logic               w_unused;

    assign w_id_alu_op  = ex_ctrl_i[ALUOP_W+1:2];
    assign w_id_alu_src = ex_ctrl_i[1];
    assign w_id_reg_dst = ex_ctrl_i[0];
    assign w_id_dst     = w_id_reg_dst ? rd_i : rt_i;
    assign w_id_bubble  = w_stall | flush_i | ~id_valid_i;

    // Branch/jump qualifier is consumed by the PC unit, not here.
    assign w_unused = pc_ctrl_i[0];

    // ------------------------------------------------------------------
    // ID/EX register
    // ------------------------------------------------------------------
    logic               r_ex_valid;
    logic [ALUOP_W-1:0] r_ex_alu_op;
    logic               r_ex_alu_src;
    logic               r_ex_mem_cs;
    logic               r_ex_mem_we;
    logic               r_ex_wb_mux;
    logic               r_ex_reg_we;
    logic [RA_W-1:0]    r_ex_dst;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || w_id_bubble) begin
            r_ex_valid   <= 1'b0;
            r_ex_alu_op  <= '0;
            r_ex_alu_src <= 1'b0;
            r_ex_mem_cs  <= 1'b0;
            r_ex_mem_we  <= 1'b0;
            r_ex_wb_mux  <= 1'b0;
            r_ex_reg_we  <= 1'b0;
            r_ex_dst     <= '0;
        end else begin
            r_ex_valid   <= 1'b1;
            r_ex_alu_op  <= w_id_alu_op;
            r_ex_alu_src <= w_id_alu_src;
            r_ex_mem_cs  <= mem_ctrl_i[1];
            r_ex_mem_we  <= mem_ctrl_i[0];
            r_ex_wb_mux  <= wb_ctrl_i[1];
            r_ex_reg_we  <= wb_ctrl_i[0];
            r_ex_dst     <= w_id_dst;
        end
    end

    // ------------------------------------------------------------------
    // EX/MEM register (never stalled)
    // ------------------------------------------------------------------
    logic            r_mem_valid;
    logic            r_mem_cs;
    logic            r_mem_we;
    logic            r_mem_wb_mux;
    logic            r_mem_reg_we;
    logic [RA_W-1:0] r_mem_dst;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_mem_valid  <= 1'b0;
            r_mem_cs     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_wb_mux <= 1'b0;
            r_mem_reg_we <= 1'b0;
            r_mem_dst    <= '0;
        end else begin
            r_mem_valid  <= r_ex_valid;
            r_mem_cs     <= r_ex_mem_cs;
            r_mem_we     <= r_ex_mem_we;
            r_mem_wb_mux <= r_ex_wb_mux;
            r_mem_reg_we <= r_ex_reg_we;
            r_mem_dst    <= r_ex_dst;
        end
    end

    // ------------------------------------------------------------------
    // MEM/WB register (never stalled)
    // ------------------------------------------------------------------
    logic            r_wb_valid;
    logic            r_wb_mux;
    logic            r_wb_reg_we;
    logic [RA_W-1:0] r_wb_dst;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_wb_valid  <= 1'b0;
            r_wb_mux    <= 1'b0;
            r_wb_reg_we <= 1'b0;
            r_wb_dst    <= '0;
        end else begin
            r_wb_valid  <= r_mem_valid;
            r_wb_mux    <= r_mem_wb_mux;
            r_wb_reg_we <= r_mem_reg_we;
            r_wb_dst    <= r_mem_dst;
        end
    end

`ifdef CTRL_PIPE_FWD_EN
    localparam logic [1:0] c_fwd_exmem = 2'b10;
    localparam logic [1:0] c_fwd_memwb = 2'b01;

    logic [RA_W-1:0] r_ex_rs;
    logic [RA_W-1:0] r_ex_rt;
    logic            w_ex_load;
    logic            w_exmem_src;
    logic            w_memwb_src;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || w_id_bubble) begin
            r_ex_rs <= '0;
            r_ex_rt <= '0;
        end else begin
            r_ex_rs <= rs_i;
            r_ex_rt <= rt_i;
        end
    end

    // Only a load in EX cannot be forwarded in time; rt is compared even for I-type.
    assign w_ex_load = r_ex_valid & r_ex_mem_cs & ~r_ex_mem_we & r_ex_reg_we
                     & (r_ex_dst != c_reg_zero);
    assign w_hazard  = w_ex_load & ((r_ex_dst == rs_i) | (r_ex_dst == rt_i));

    // Loads sitting in EX/MEM are excluded: their data only exists from MEM/WB.
    assign w_exmem_src = r_mem_valid & r_mem_reg_we & r_mem_wb_mux & (r_mem_dst != c_reg_zero);
    assign w_memwb_src = r_wb_valid & r_wb_reg_we & (r_wb_dst != c_reg_zero);

    always_comb begin
        fwd_a_o = c_fwd_rf;
        fwd_b_o = c_fwd_rf;
        if (w_exmem_src && (r_mem_dst == r_ex_rs)) begin
            fwd_a_o = c_fwd_exmem;
        end else if (w_memwb_src && (r_wb_dst == r_ex_rs)) begin
            fwd_a_o = c_fwd_memwb;
        end
        if (w_exmem_src && (r_mem_dst == r_ex_rt)) begin
            fwd_b_o = c_fwd_exmem;
        end else if (w_memwb_src && (r_wb_dst == r_ex_rt)) begin
            fwd_b_o = c_fwd_memwb;
        end
    end
`else
    logic w_ex_writes;
    logic w_mem_writes;
    logic w_rs_busy;
    logic w_rt_busy;

    // Without bypass paths, hold ID until producers reach WB (write-before-read regfile).
    assign w_ex_writes  = r_ex_valid & r_ex_reg_we;
    assign w_mem_writes = r_mem_valid & r_mem_reg_we;
    assign w_rs_busy    = (rs_i != c_reg_zero)
                        & ((w_ex_writes & (r_ex_dst == rs_i)) | (w_mem_writes & (r_mem_dst == rs_i)));
    assign w_rt_busy    = (rt_i != c_reg_zero)
                        & ((w_ex_writes & (r_ex_dst == rt_i)) | (w_mem_writes & (r_mem_dst == rt_i)));
    assign w_hazard     = w_rs_busy | w_rt_busy;

    assign fwd_a_o = c_fwd_rf;
    assign fwd_b_o = c_fwd_rf;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_stall    = rst_n_i & id_valid_i & w_hazard;
    assign stall_o    = w_stall;
    assign pc_write_o = ~w_stall;
    // A redirect seen during a stall is acted on when the ID cycle replays.
    assign flush_if_o = rst_n_i & id_valid_i & pc_ctrl_i[1] & ~w_stall;

    assign alu_op_o  = r_ex_alu_op;
    assign alu_src_o = r_ex_alu_src;
    assign mem_cs_o  = r_mem_valid & r_mem_cs;
    assign mem_we_o  = r_mem_valid & r_mem_we;
    assign wb_mux_o  = r_wb_valid & r_wb_mux;
    assign reg_we_o  = r_wb_valid & r_wb_reg_we & (r_wb_dst != c_reg_zero);
    assign wb_dst_o  = r_wb_dst;

endmodule
`default_nettype wire

// File: tb/tb_control_pipeline.sv
`default_nettype none
// Testbench for control_pipeline: per-cycle ID vectors with expected stall/flush/forward,
// stage outputs checked through a three-queue scoreboard.
module tb_control_pipeline;

`ifdef CTRL_PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // ex_ctrl = {ALUop[2:0], ALUsrc, RegDst}
    localparam logic [4:0] EX_ADD  = 5'b010_0_1;
    localparam logic [4:0] EX_SUB  = 5'b110_0_1;
    localparam logic [4:0] EX_LW   = 5'b010_1_0;
    localparam logic [4:0] EX_ADDI = 5'b010_1_0;
    localparam logic [4:0] EX_BEQ  = 5'b110_0_0;

    logic       clk_i, rst_n_i, id_valid_i, flush_i;
    logic [1:0] pc_ctrl_i, mem_ctrl_i, wb_ctrl_i;
    logic [4:0] ex_ctrl_i, rs_i, rt_i, rd_i;
    logic [2:0] alu_op_o;
    logic       alu_src_o, mem_cs_o, mem_we_o, wb_mux_o, reg_we_o;
    logic [1:0] fwd_a_o, fwd_b_o;
    logic [4:0] wb_dst_o;
    logic       stall_o, pc_write_o, flush_if_o;

    control_pipeline #(.RA_W(5), .ALUOP_W(3)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .id_valid_i(id_valid_i), .pc_ctrl_i(pc_ctrl_i),
        .ex_ctrl_i(ex_ctrl_i), .mem_ctrl_i(mem_ctrl_i), .wb_ctrl_i(wb_ctrl_i),
        .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .flush_i(flush_i),
        .alu_op_o(alu_op_o), .alu_src_o(alu_src_o), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
        .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .wb_mux_o(wb_mux_o), .reg_we_o(reg_we_o),
        .wb_dst_o(wb_dst_o), .stall_o(stall_o), .pc_write_o(pc_write_o), .flush_if_o(flush_if_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       rst_n;
        logic       valid;
        logic [1:0] pc;
        logic [4:0] ex;
        logic [1:0] mem;
        logic [1:0] wb;
        logic [4:0] rs, rt, rd;
        logic       flush;
        logic       st;     // expected stall_o in this ID cycle
        logic       fi;     // expected flush_if_o in this ID cycle
        logic [1:0] fa, fb; // expected selects in this instruction's EX cycle
    } row_t;

    typedef struct {
        logic [2:0] alu_op;
        logic       alu_src;
        logic [1:0] fa, fb;
        logic       mem_cs, mem_we, wb_mux, reg_we;
        logic [4:0] dst;
    } exp_t;

    row_t tbl[$];
    exp_t q_ex[$], q_mem[$], q_wb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    function automatic row_t mk(input logic v, input logic [1:0] pc, input logic [4:0] ex,
                                input logic [1:0] mem, input logic [1:0] wb,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                input logic fl, input logic st, input logic fi,
                                input logic [1:0] fa, input logic [1:0] fb);
        row_t r;
        r.rst_n = 1'b1; r.valid = v; r.pc = pc; r.ex = ex; r.mem = mem; r.wb = wb;
        r.rs = rs; r.rt = rt; r.rd = rd; r.flush = fl; r.st = st; r.fi = fi; r.fa = fa; r.fb = fb;
        return r;
    endfunction

    function automatic exp_t bubble();
        exp_t e;
        e.alu_op = '0; e.alu_src = 1'b0; e.fa = '0; e.fb = '0;
        e.mem_cs = 1'b0; e.mem_we = 1'b0; e.wb_mux = 1'b0; e.reg_we = 1'b0; e.dst = '0;
        return e;
    endfunction

    task automatic alu(input logic [4:0] ex, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic st, input logic [1:0] fa, input logic [1:0] fb);
        tbl.push_back(mk(1'b1, 2'b00, ex, 2'b00, 2'b11, rs, rt, rd, 1'b0, st, 1'b0, fa, fb));
    endtask

    task automatic lw(input logic [4:0] rs, input logic [4:0] rt);
        tbl.push_back(mk(1'b1, 2'b00, EX_LW, 2'b10, 2'b01, rs, rt, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00));
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++)
            tbl.push_back(mk(1'b0, 2'b00, 5'd0, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00));
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, expv);
        end
    endtask

    task automatic sb_init();
        q_ex.delete(); q_mem.delete(); q_wb.delete();
        q_mem.push_back(bubble());
        q_wb.push_back(bubble());
        q_wb.push_back(bubble());
    endtask

    // One ID cycle: drive, check combinational outputs, clock, check stage outputs.
    task automatic step(input row_t r);
        exp_t e, ge, gm, gw;
        logic [4:0] dst;
        rst_n_i = r.rst_n; id_valid_i = r.valid; pc_ctrl_i = r.pc; ex_ctrl_i = r.ex;
        mem_ctrl_i = r.mem; wb_ctrl_i = r.wb; rs_i = r.rs; rt_i = r.rt; rd_i = r.rd; flush_i = r.flush;
        #3;
        chk("stall_o", 8'(stall_o), 8'(r.st));
        chk("pc_write_o", 8'(pc_write_o), 8'(r.st == 1'b0));
        chk("flush_if_o", 8'(flush_if_o), 8'(r.fi));
        @(posedge clk_i);
        #1;
        cyc++;
        if (!r.rst_n) sb_init();
        e = bubble();
        if (r.rst_n && r.valid && !r.st && !r.flush) begin
            dst       = r.ex[0] ? r.rd : r.rt;
            e.alu_op  = r.ex[4:2];
            e.alu_src = r.ex[1];
            e.fa      = r.fa;
            e.fb      = r.fb;
            e.mem_cs  = r.mem[1];
            e.mem_we  = r.mem[0];
            e.wb_mux  = r.wb[1];
            e.reg_we  = r.wb[0] && (dst != 5'd0);
            e.dst     = dst;
        end
        q_ex.push_back(e); q_mem.push_back(e); q_wb.push_back(e);
        ge = q_ex.pop_front(); gm = q_mem.pop_front(); gw = q_wb.pop_front();
        chk("alu_op_o", 8'(alu_op_o), 8'(ge.alu_op));
        chk("alu_src_o", 8'(alu_src_o), 8'(ge.alu_src));
        chk("fwd_a_o", 8'(fwd_a_o), 8'(ge.fa));
        chk("fwd_b_o", 8'(fwd_b_o), 8'(ge.fb));
        chk("mem_cs_o", 8'(mem_cs_o), 8'(gm.mem_cs));
        chk("mem_we_o", 8'(mem_we_o), 8'(gm.mem_we));
        chk("wb_mux_o", 8'(wb_mux_o), 8'(gw.wb_mux));
        chk("reg_we_o", 8'(reg_we_o), 8'(gw.reg_we));
        chk("wb_dst_o", 8'(wb_dst_o), 8'(gw.dst));
    endtask

    initial begin
        row_t rr;

        // A: ADD r3 then SUB rs=r3 back-to-back
        alu(EX_ADD, 5'd1, 5'd2, 5'd3, 1'b0, 2'b00, 2'b00);
        if (FWD) begin
            alu(EX_SUB, 5'd3, 5'd4, 5'd6, 1'b0, 2'b10, 2'b00);
        end else begin
            alu(EX_SUB, 5'd3, 5'd4, 5'd6, 1'b1, 2'b00, 2'b00);
            alu(EX_SUB, 5'd3, 5'd4, 5'd6, 1'b1, 2'b00, 2'b00);
            alu(EX_SUB, 5'd3, 5'd4, 5'd6, 1'b0, 2'b00, 2'b00);
        end
        nops(3);
        // H: both EX/MEM and MEM/WB write r3; EX/MEM wins
        alu(EX_ADD, 5'd1, 5'd2, 5'd3, 1'b0, 2'b00, 2'b00);
        alu(EX_ADD, 5'd1, 5'd2, 5'd3, 1'b0, 2'b00, 2'b00);
        if (FWD) begin
            alu(EX_SUB, 5'd3, 5'd0, 5'd6, 1'b0, 2'b10, 2'b00);
        end else begin
            alu(EX_SUB, 5'd3, 5'd0, 5'd6, 1'b1, 2'b00, 2'b00);
            alu(EX_SUB, 5'd3, 5'd0, 5'd6, 1'b1, 2'b00, 2'b00);
            alu(EX_SUB, 5'd3, 5'd0, 5'd6, 1'b0, 2'b00, 2'b00);
        end
        nops(3);
        // B: producer one instruction ahead
        alu(EX_ADD, 5'd1, 5'd2, 5'd7, 1'b0, 2'b00, 2'b00);
        nops(1);
        if (FWD) begin
            alu(EX_SUB, 5'd7, 5'd1, 5'd8, 1'b0, 2'b01, 2'b00);
        end else begin
            alu(EX_SUB, 5'd7, 5'd1, 5'd8, 1'b1, 2'b00, 2'b00);
            alu(EX_SUB, 5'd7, 5'd1, 5'd8, 1'b0, 2'b00, 2'b00);
        end
        nops(3);
        // C: LW r5 then ADD rt=r5
        lw(5'd1, 5'd5);
        alu(EX_ADD, 5'd2, 5'd5, 5'd9, 1'b1, 2'b00, 2'b00);
        if (FWD) begin
            alu(EX_ADD, 5'd2, 5'd5, 5'd9, 1'b0, 2'b00, 2'b01);
        end else begin
            alu(EX_ADD, 5'd2, 5'd5, 5'd9, 1'b1, 2'b00, 2'b00);
            alu(EX_ADD, 5'd2, 5'd5, 5'd9, 1'b0, 2'b00, 2'b00);
        end
        nops(3);
        // D: $0 destination and $0 source
        alu(EX_ADDI, 5'd1, 5'd0, 5'd0, 1'b0, 2'b00, 2'b00);
        alu(EX_ADD, 5'd0, 5'd2, 5'd10, 1'b0, 2'b00, 2'b00);
        nops(3);
        // E: jump
        tbl.push_back(mk(1'b1, 2'b10, 5'd0, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00));
        nops(1);
        // F: taken branch that is also a load-use consumer
        lw(5'd1, 5'd4);
        tbl.push_back(mk(1'b1, 2'b11, EX_BEQ, 2'b00, 2'b00, 5'd4, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00));
        if (FWD) begin
            tbl.push_back(mk(1'b1, 2'b11, EX_BEQ, 2'b00, 2'b00, 5'd4, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00));
        end else begin
            tbl.push_back(mk(1'b1, 2'b11, EX_BEQ, 2'b00, 2'b00, 5'd4, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00));
            tbl.push_back(mk(1'b1, 2'b11, EX_BEQ, 2'b00, 2'b00, 5'd4, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00));
        end
        nops(3);
        // G: external flush, alone and together with a stall
        tbl.push_back(mk(1'b1, 2'b00, EX_ADD, 2'b00, 2'b11, 5'd1, 5'd2, 5'd11, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00));
        lw(5'd1, 5'd12);
        tbl.push_back(mk(1'b1, 2'b00, EX_ADD, 2'b00, 2'b11, 5'd12, 5'd2, 5'd13, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00));
        if (FWD) begin
            alu(EX_ADD, 5'd12, 5'd2, 5'd13, 1'b0, 2'b01, 2'b00);
        end else begin
            alu(EX_ADD, 5'd12, 5'd2, 5'd13, 1'b1, 2'b00, 2'b00);
            alu(EX_ADD, 5'd12, 5'd2, 5'd13, 1'b0, 2'b00, 2'b00);
        end
        nops(3);
        // I: invalid ID slot never stalls or flushes
        lw(5'd1, 5'd6);
        tbl.push_back(mk(1'b0, 2'b10, EX_ADD, 2'b00, 2'b11, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00));
        nops(3);

        // Reset held two cycles with live control on the inputs
        rr = mk(1'b1, 2'b11, EX_ADD, 2'b00, 2'b11, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        rr.rst_n = 1'b0;
        step(rr);
        step(rr);

        foreach (tbl[i]) step(tbl[i]);

        // Reset with three instructions in flight, then no write-back afterwards
        step(mk(1'b1, 2'b00, EX_ADD, 2'b00, 2'b11, 5'd1, 5'd2, 5'd13, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00));
        step(mk(1'b1, 2'b00, EX_ADD, 2'b00, 2'b11, 5'd1, 5'd2, 5'd14, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00));
        step(mk(1'b1, 2'b00, EX_ADD, 2'b00, 2'b11, 5'd1, 5'd2, 5'd15, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00));
        rr = mk(1'b1, 2'b10, EX_ADD, 2'b00, 2'b11, 5'd15, 5'd0, 5'd16, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        rr.rst_n = 1'b0;
        step(rr);
        for (int i = 0; i < 4; i++)
            step(mk(1'b0, 2'b00, 5'd0, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
